fsd_report_rx: RTL

Decoder for the FSd1 measurement report stream: consumes UART bytes (from an RX8 instance), parses the comma-separated decimal frame that FSd1 emits, and presents the six counter values as binary registers. It is the receiving end of the report link and is used on a host-side or loopback board to recover `raw_cnt[0..2]` and `sig_cnt[0..2]`. Outputs update only atomically, on a fully valid frame.

---
 rtl/fsd_report_rx.sv | 118 +++++++++++
 1 files changed

// File: rtl/fsd_report_rx.sv
// fsd_report_rx: parses FSd1 comma-separated decimal report frames into binary counter registers
module fsd_report_rx #(
   parameter int RAW_DIGITS = 4,
   parameter int SIG_DIGITS = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk24M,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_ready,
   output logic [11:0]      raw0,
   output logic [11:0]      raw1,
   output logic [11:0]      raw2,
   output logic [23:0]      sig0,
   output logic [23:0]      sig1,
   output logic [23:0]      sig2,
   output logic             frame_valid,
   output logic             frame_err,
   output logic [15:0]      frame_cnt,
   output logic [ERR_W-1:0] err_cnt,
   output logic             synced
);
   typedef enum logic [1:0] {HUNT, FIELD, LF_WAIT} state_t;
   state_t state;
   logic rx_ready_p;
   logic [26:0] acc;
   logic [26:0] acc_next;
   logic [3:0] dcnt;
   logic [2:0] fidx;
   logic [23:0] stg [6];
   logic take;
   logic is_digit;
   logic is_lf;
   logic sig_field;
   logic field_ok;
   logic bad;
   logic [3:0] req;
   // byte classification, field check and error decision for the byte currently on rx_data
   always_comb begin
      take = rx_ready && !rx_ready_p;
      is_digit = rx_data >= 8'h30 && rx_data <= 8'h39;
      is_lf = rx_data == 8'h0A;
      sig_field = fidx >= 3'd3;
      req = sig_field ? 4'(SIG_DIGITS) : 4'(RAW_DIGITS);
      field_ok = dcnt == req && acc <= (sig_field ? 27'hFF_FFFF : 27'h000_0FFF);
      acc_next = (acc << 3) + (acc << 1) + 27'(rx_data[3:0]);
      bad = state == LF_WAIT ? !is_lf :
            state != FIELD ? 1'b0 :
            is_digit ? dcnt >= req :
            rx_data == 8'h2C ? fidx == 3'd5 || !field_ok :
            rx_data == 8'h0D ? fidx != 3'd5 || !field_ok : 1'b1;
      synced = state != HUNT;
   end
   // frame parser: every accepted byte is fully handled on the edge that sees rx_ready rise
   always_ff @(posedge clk24M) begin
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      rx_ready_p <= rx_ready;
      if (rst) begin
         state <= HUNT;
         acc <= '0;
         dcnt <= '0;
         fidx <= '0;
         for (int i = 0; i < 6; i++) stg[i] <= '0;
         raw0 <= '0;
         raw1 <= '0;
         raw2 <= '0;
         sig0 <= '0;
         sig1 <= '0;
         sig2 <= '0;
         frame_cnt <= '0;
         err_cnt <= '0;
      end else if (take && bad) begin
         frame_err <= 1'b1;
         err_cnt <= &err_cnt ? err_cnt : err_cnt + ERR_W'(1);
         state <= is_lf ? FIELD : HUNT;
         acc <= '0;
         dcnt <= '0;
         fidx <= '0;
      end else if (take) begin
         unique case (state)
            HUNT: begin
               state <= is_lf ? FIELD : HUNT;
               acc <= '0;
               dcnt <= '0;
               fidx <= '0;
            end
            FIELD: begin
               if (is_digit) begin
                  acc <= acc_next;
                  dcnt <= dcnt + 4'd1;
               end else begin
                  stg[fidx] <= acc[23:0];
                  acc <= '0;
                  dcnt <= '0;
                  if (rx_data == 8'h0D) state <= LF_WAIT;
                  else fidx <= fidx + 3'd1;
               end
            end
            LF_WAIT: begin
               raw0 <= stg[0][11:0];
               raw1 <= stg[1][11:0];
               raw2 <= stg[2][11:0];
               sig0 <= stg[3];
               sig1 <= stg[4];
               sig2 <= stg[5];
               frame_valid <= 1'b1;
               frame_cnt <= frame_cnt + 16'd1;
               state <= FIELD;
               acc <= '0;
               dcnt <= '0;
               fidx <= '0;
            end
            default: state <= HUNT;
         endcase
      end
   end
endmodule
